// File: rtl/rgb_pwm_driver.sv
// Three-channel active-low LED PWM driver with a one-entry colour buffer applied at period boundaries.
// Optional build macro SLEW_LIMIT_EN: duties fade one step per period toward the latest accepted colour.
`timescale 1ns/1ps
module rgb_pwm_driver #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  input  logic       enable,
  output logic       period_start,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic          pending_full;
  logic [7:0]    pend_r, pend_g, pend_b;
  logic [7:0]    act_r, act_g, act_b;
  logic          tick, boundary, transfer;

  // Handshake: a triple moves when in_valid && in_ready on a rising clock edge;
  // upstream keeps data stable while in_valid is high and in_ready is low.
  assign in_ready = !pending_full;
  assign transfer = in_valid && in_ready;
  assign tick     = (pre == PW'(PRESCALE - 1));
  assign boundary = tick && (cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      cnt          <= 8'd0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (tick) begin
        pre <= '0;
        cnt <= cnt + 8'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  // A transfer can only happen with the buffer empty, so it never races the boundary clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      pend_r       <= 8'd0;
      pend_g       <= 8'd0;
      pend_b       <= 8'd0;
    end else if (transfer) begin
      pending_full <= 1'b1;
      pend_r       <= in_red;
      pend_g       <= in_green;
      pend_b       <= in_blue;
    end else if (boundary) begin
      pending_full <= 1'b0;
    end
  end

`ifdef SLEW_LIMIT_EN
  logic [7:0] tgt_r, tgt_g, tgt_b;
  logic [7:0] ntgt_r, ntgt_g, ntgt_b;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
    if (cur < goal)      return cur + 8'd1;
    else if (cur > goal) return cur - 8'd1;
    else                 return cur;
  endfunction

  // The step uses the target as updated on this same boundary.
  assign ntgt_r = pending_full ? pend_r : tgt_r;
  assign ntgt_g = pending_full ? pend_g : tgt_g;
  assign ntgt_b = pending_full ? pend_b : tgt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_r <= 8'd0;
      tgt_g <= 8'd0;
      tgt_b <= 8'd0;
      act_r <= 8'd0;
      act_g <= 8'd0;
      act_b <= 8'd0;
    end else if (boundary) begin
      tgt_r <= ntgt_r;
      tgt_g <= ntgt_g;
      tgt_b <= ntgt_b;
      act_r <= step_toward(act_r, ntgt_r);
      act_g <= step_toward(act_g, ntgt_g);
      act_b <= step_toward(act_b, ntgt_b);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r <= 8'd0;
      act_g <= 8'd0;
      act_b <= 8'd0;
    end else if (boundary && pending_full) begin
      act_r <= pend_r;
      act_g <= pend_g;
      act_b <= pend_b;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGB_R <= 1'b1;
      RGB_G <= 1'b1;
      RGB_B <= 1'b1;
    end else begin
      RGB_R <= !(enable && (cnt < act_r));
      RGB_G <= !(enable && (cnt < act_g));
      RGB_B <= !(enable && (cnt < act_b));
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: directed scenarios measured per PWM period plus a randomized
// run compared cycle by cycle against a period-arithmetic reference model.
`timescale 1ns/1ps
module tb_rgb_pwm_driver;
  localparam int P      = 1;
  localparam int PERIOD = 256 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_red, in_green, in_blue;
  logic       enable;
  logic       period_start;
  logic       RGB_R, RGB_G, RGB_B;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .enable(enable),
    .period_start(period_start), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  // Reference model: position in the period comes from clocks elapsed since reset.
  int         m_t;
  bit         m_full;
  logic [7:0] m_pend[3];
  logic [7:0] m_act[3];
  logic       exp_pin[3];
  logic       exp_ps;
`ifdef SLEW_LIMIT_EN
  logic [7:0] m_tgt[3];
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= 0;
      m_full <= 1'b0;
      exp_ps <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_pend[i]  <= 8'd0;
        m_act[i]   <= 8'd0;
        exp_pin[i] <= 1'b1;
`ifdef SLEW_LIMIT_EN
        m_tgt[i]   <= 8'd0;
`endif
      end
    end else begin : model_step
      automatic int phase = (m_t / P) % 256;
      automatic bit at_boundary = ((m_t + 1) % PERIOD) == 0;
      automatic logic [7:0] din[3];
      automatic logic [7:0] nact[3];
`ifdef SLEW_LIMIT_EN
      automatic logic [7:0] ntgt[3];
      ntgt = m_tgt;
`endif
      din[0] = in_red; din[1] = in_green; din[2] = in_blue;
      nact = m_act;
      for (int i = 0; i < 3; i++) exp_pin[i] <= !(enable && (phase < int'(m_act[i])));
      if (at_boundary) begin
`ifdef SLEW_LIMIT_EN
        if (m_full) ntgt = m_pend;
        for (int i = 0; i < 3; i++) begin
          if (nact[i] < ntgt[i]) nact[i] = nact[i] + 8'd1;
          else if (nact[i] > ntgt[i]) nact[i] = nact[i] - 8'd1;
        end
`else
        if (m_full) nact = m_pend;
`endif
      end
      m_act <= nact;
`ifdef SLEW_LIMIT_EN
      m_tgt <= ntgt;
`endif
      exp_ps <= at_boundary;
      if (in_valid && !m_full) begin
        m_pend <= din;
        m_full <= 1'b1;
      end else if (at_boundary) begin
        m_full <= 1'b0;
      end
      m_t <= m_t + 1;
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_boundary(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PERIOD + 8; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on a boundary negedge; returns on the next boundary negedge.
  task automatic measure_period(output int lr, output int lg, output int lb, output logic rdy_first);
    lr = 0; lg = 0; lb = 0; rdy_first = 1'bx;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rdy_first = in_ready;
        in_valid  = 1'b0;
      end
      if (RGB_R === 1'b0) lr++;
      if (RGB_G === 1'b0) lg++;
      if (RGB_B === 1'b0) lb++;
    end
  endtask

  task automatic test_reset;
    int got;
    rst_n = 1'b0; in_valid = 1'b0; enable = 1'b1;
    in_red = 8'd0; in_green = 8'd0; in_blue = 8'd0;
    skip(3);
    n_vec++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b111) begin
      $display("FAIL reset_pins: got %b expected 111", {RGB_R, RGB_G, RGB_B}); n_err++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_ready: got %b expected 1", in_ready); n_err++; end
    n_vec++;
    if (period_start !== 1'b0) begin $display("FAIL reset_period_start: got %b expected 0", period_start); n_err++; end
    rst_n = 1'b1;
    got = -1;
    for (int k = 1; k <= PERIOD + 8; k++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin got = k; break; end
    end
    n_vec++;
    if (got != PERIOD) begin $display("FAIL first_boundary: got %0d clocks expected %0d", got, PERIOD); n_err++; end
  endtask

  task automatic test_duty;
    int lr, lg, lb; logic rf; bit ok; logic [23:0] e;
    skip(50);
    in_red = 8'd64; in_green = 8'd128; in_blue = 8'd255; in_valid = 1'b1;
    exp_q.push_back({8'd64, 8'd128, 8'd255});
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin $display("FAIL duty_ready_fall: got %b expected 0", in_ready); n_err++; end
    in_valid = 1'b0;
    wait_boundary(ok);
    n_vec++;
    if (!ok) begin $display("FAIL duty_boundary: got timeout expected period_start"); n_err++; end
    n_vec++;
    if (in_ready !== 1'b1) begin $display("FAIL duty_ready_rise: got %b expected 1", in_ready); n_err++; end
    measure_period(lr, lg, lb, rf);
    e = exp_q.pop_front();
    n_vec++;
    if (lr != int'(e[23:16]) || lg != int'(e[15:8]) || lb != int'(e[7:0])) begin
      $display("FAIL duty_lows: got %0d/%0d/%0d expected %0d/%0d/%0d", lr, lg, lb, e[23:16], e[15:8], e[7:0]);
      n_err++;
    end
  endtask

  task automatic test_back_to_back;
    int lr, lg, lb; logic rf; bit ok; logic [23:0] e;
    logic [7:0] xr, xg, xb;
    xr = 8'($urandom_range(0, 255)); xg = 8'($urandom_range(0, 255)); xb = 8'($urandom_range(0, 255));
    skip(20);
    in_red = xr; in_green = xg; in_blue = xb; in_valid = 1'b1;
    exp_q.push_back({xr, xg, xb});
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin $display("FAIL b2b_first_accept: got ready %b expected 0", in_ready); n_err++; end
    in_red = 8'd10; in_green = 8'd20; in_blue = 8'd30;
    exp_q.push_back({8'd10, 8'd20, 8'd30});
    ok = 1'b0;
    for (int i = 0; i < PERIOD + 8; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin ok = 1'b1; break; end
      n_vec++;
      if (in_ready !== 1'b0) begin $display("FAIL b2b_hold_ready: got %b expected 0", in_ready); n_err++; end
    end
    n_vec++;
    if (!ok) begin $display("FAIL b2b_boundary: got timeout expected period_start"); n_err++; end
    n_vec++;
    if (in_ready !== 1'b1) begin $display("FAIL b2b_ready_rise: got %b expected 1", in_ready); n_err++; end
    measure_period(lr, lg, lb, rf);
    n_vec++;
    if (rf !== 1'b0) begin $display("FAIL b2b_second_accept: got ready %b expected 0", rf); n_err++; end
    e = exp_q.pop_front();
    n_vec++;
    if (lr != int'(e[23:16]) || lg != int'(e[15:8]) || lb != int'(e[7:0])) begin
      $display("FAIL b2b_first_lows: got %0d/%0d/%0d expected %0d/%0d/%0d", lr, lg, lb, e[23:16], e[15:8], e[7:0]);
      n_err++;
    end
    measure_period(lr, lg, lb, rf);
    e = exp_q.pop_front();
    n_vec++;
    if (lr != int'(e[23:16]) || lg != int'(e[15:8]) || lb != int'(e[7:0])) begin
      $display("FAIL b2b_second_lows: got %0d/%0d/%0d expected %0d/%0d/%0d", lr, lg, lb, e[23:16], e[15:8], e[7:0]);
      n_err++;
    end
  endtask

  task automatic test_boundary_transfer;
    int lr, lg, lb; logic rf; logic [23:0] e;
    logic [7:0] cr, cg, cb;
    cr = 8'($urandom_range(0, 255)); cg = 8'($urandom_range(0, 255)); cb = 8'($urandom_range(0, 255));
    skip(PERIOD - 1);
    n_vec++;
    if (in_ready !== 1'b1) begin $display("FAIL bt_ready_pre: got %b expected 1", in_ready); n_err++; end
    in_red = cr; in_green = cg; in_blue = cb; in_valid = 1'b1;
    exp_q.push_back({8'd10, 8'd20, 8'd30});
    exp_q.push_back({cr, cg, cb});
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (period_start !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL bt_same_edge: got ps=%b ready=%b expected ps=1 ready=0", period_start, in_ready); n_err++;
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(lr, lg, lb, rf);
      e = exp_q.pop_front();
      n_vec++;
      if (lr != int'(e[23:16]) || lg != int'(e[15:8]) || lb != int'(e[7:0])) begin
        $display("FAIL bt_lows_period%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", p, lr, lg, lb, e[23:16], e[15:8], e[7:0]);
        n_err++;
      end
    end
  endtask

  task automatic test_zero_and_enable;
    int lr, lg, lb; logic rf; bit ok;
    in_red = 8'd0; in_green = 8'd0; in_blue = 8'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_boundary(ok);
    measure_period(lr, lg, lb, rf);
    n_vec++;
    if (!ok || lr != 0 || lg != 0 || lb != 0) begin
      $display("FAIL zero_duty: got ok=%0d lows %0d/%0d/%0d expected 0/0/0", ok, lr, lg, lb); n_err++;
    end
    enable = 1'b0;
    in_red = 8'd255; in_green = 8'd255; in_blue = 8'd255; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_boundary(ok);
    measure_period(lr, lg, lb, rf);
    n_vec++;
    if (!ok || lr != 0 || lg != 0 || lb != 0) begin
      $display("FAIL enable_off: got ok=%0d lows %0d/%0d/%0d expected 0/0/0", ok, lr, lg, lb); n_err++;
    end
    skip(10);
    enable = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b000) begin
      $display("FAIL enable_restore: got %b expected 000", {RGB_R, RGB_G, RGB_B}); n_err++;
    end
    wait_boundary(ok);
    measure_period(lr, lg, lb, rf);
    n_vec++;
    if (!ok || lr != 255 || lg != 255 || lb != 255) begin
      $display("FAIL full_duty: got ok=%0d lows %0d/%0d/%0d expected 255/255/255", ok, lr, lg, lb); n_err++;
    end
  endtask

  task automatic test_reset_mid;
    int lr, lg, lb; logic rf; bit ok;
    skip(30);
    in_red = 8'($urandom_range(1, 255)); in_green = 8'($urandom_range(1, 255));
    in_blue = 8'($urandom_range(1, 255)); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b000) begin
      $display("FAIL rmid_pre_pins: got %b expected 000", {RGB_R, RGB_G, RGB_B}); n_err++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b111 || in_ready !== 1'b1) begin
      $display("FAIL rmid_async: got pins %b ready %b expected 111 ready 1", {RGB_R, RGB_G, RGB_B}, in_ready); n_err++;
    end
    skip(3);
    rst_n = 1'b1;
    wait_boundary(ok);
    measure_period(lr, lg, lb, rf);
    n_vec++;
    if (!ok || lr != 0 || lg != 0 || lb != 0) begin
      $display("FAIL rmid_discard: got ok=%0d lows %0d/%0d/%0d expected 0/0/0", ok, lr, lg, lb); n_err++;
    end
  endtask

`ifdef SLEW_LIMIT_EN
  task automatic test_slew;
    int lr, lg, lb, er; logic rf; bit ok;
    skip(40);
    in_red = 8'd4; in_green = 8'd0; in_blue = 8'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_boundary(ok);
    n_vec++;
    if (!ok) begin $display("FAIL slew_boundary: got timeout expected period_start"); n_err++; end
    for (int p = 1; p <= 5; p++) begin
      er = (p < 4) ? p : 4;
      measure_period(lr, lg, lb, rf);
      n_vec++;
      if (lr != er || lg != 0 || lb != 0) begin
        $display("FAIL slew_period%0d: got %0d/%0d/%0d expected %0d/0/0", p, lr, lg, lb, er); n_err++;
      end
    end
  endtask
`endif

  task automatic test_random_model;
    logic rdy_prev;
    bit accepted;
    rdy_prev = in_ready;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n_vec++;
      if (RGB_R !== exp_pin[0] || RGB_G !== exp_pin[1] || RGB_B !== exp_pin[2]) begin
        $display("FAIL rand_pins@%0d: got %b%b%b expected %b%b%b", i, RGB_R, RGB_G, RGB_B,
                 exp_pin[0], exp_pin[1], exp_pin[2]);
        n_err++;
      end
      n_vec++;
      if (in_ready !== !m_full) begin
        $display("FAIL rand_ready@%0d: got %b expected %b", i, in_ready, !m_full); n_err++;
      end
      n_vec++;
      if (period_start !== exp_ps) begin
        $display("FAIL rand_period_start@%0d: got %b expected %b", i, period_start, exp_ps); n_err++;
      end
      accepted = in_valid && rdy_prev;
      if (!(in_valid && !accepted)) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_red   = 8'($urandom_range(0, 255));
        in_green = 8'($urandom_range(0, 255));
        in_blue  = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      rdy_prev = in_ready;
    end
    in_valid = 1'b0;
    enable   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
`ifdef SLEW_LIMIT_EN
    test_slew();
`else
    test_duty();
    test_back_to_back();
    test_boundary_transfer();
    test_zero_and_enable();
    test_reset_mid();
`endif
    test_random_model();
    n_vec++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
